// File: rtl/decode_r32i_pkg.sv
// Shared definitions for the RV32I decode / operand-fetch stage:
// datapath sizes, ALU operation codes, opcode and funct7 constants,
// and the packed bundle handed to the ALU.
package decode_r32i_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_N  = 32;
    localparam int unsigned IDX_W  = $clog2(REG_N);
    localparam int unsigned ALU_W  = 4;

    // ALU operation codes shared with the execute stage
    localparam logic [ALU_W-1:0] ADD  = 4'd0;
    localparam logic [ALU_W-1:0] SUB  = 4'd1;
    localparam logic [ALU_W-1:0] SLT  = 4'd2;
    localparam logic [ALU_W-1:0] SLTU = 4'd3;
    localparam logic [ALU_W-1:0] AND  = 4'd4;
    localparam logic [ALU_W-1:0] OR   = 4'd5;
    localparam logic [ALU_W-1:0] XOR  = 4'd6;
    localparam logic [ALU_W-1:0] SSL  = 4'd7;
    localparam logic [ALU_W-1:0] SSR  = 4'd8;
    localparam logic [ALU_W-1:0] SRA  = 4'd9;
    localparam logic [ALU_W-1:0] CPY  = 4'd10;

    // Supported major opcodes
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Payload registered toward the ALU
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ALU_W-1:0]  alucode;
        logic [IDX_W-1:0]  rd;
    } alu_bundle_t;

    // ALU code from funct3; alt selects SUB/SRA where the encoding allows it
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] code;
        code = ADD;
        case (f3)
            3'b000:  code = alt ? SUB : ADD;
            3'b001:  code = SSL;
            3'b010:  code = SLT;
            3'b011:  code = SLTU;
            3'b100:  code = XOR;
            3'b101:  code = alt ? SRA : SSR;
            3'b110:  code = OR;
            default: code = AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/regfileR32I.sv
// RV32I integer register file.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   i_we/i_waddr/i_wdata : synchronous write port (writes to x0 dropped)
//   i_raddr1/o_rdata1_c  : combinational read port 1 (x0 reads zero)
//   i_raddr2/o_rdata2_c  : combinational read port 2 (x0 reads zero)
module regfileR32I
    import decode_r32i_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr1,
    output logic [DATA_W-1:0] o_rdata1_c,
    input  logic [IDX_W-1:0]  i_raddr2,
    output logic [DATA_W-1:0] o_rdata2_c
);

    logic [DATA_W-1:0] r_mem [REG_N];

    // Storage: cleared on reset, x0 never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports with x0 hardwired to zero
    assign o_rdata1_c = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2_c = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/decode_r32i.sv
// RV32I decode and operand-fetch stage feeding the ALU.
// Accepts one instruction per valid/ready handshake, reads rs1/rs2 with a
// writeback bypass, forms the immediate, and registers {A, B, alucode, rd}.
// A per-register busy scoreboard holds issue on RAW/WAW hazards.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   instr_valid/instr_ready/instr   : instruction input handshake
//   out_valid/out_ready             : ALU bundle handshake
//   A, B, alucode, rd               : registered ALU bundle
//   illegal                         : one-cycle pulse after consuming an unsupported word
//   wb_en/wb_rd/wb_data             : writeback port (register write + busy clear)
module decode_r32i
    import decode_r32i_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [ALU_W-1:0]  alucode,
    output logic [IDX_W-1:0]  rd,
    output logic              illegal,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data
);

    logic [6:0]        w_opcode;
    logic [IDX_W-1:0]  w_rd;
    logic [IDX_W-1:0]  w_rs1;
    logic [IDX_W-1:0]  w_rs2;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;

    logic              w_is_op;
    logic              w_is_opimm;
    logic              w_is_lui;
    logic              w_is_shift;
    logic              w_legal;
    logic [ALU_W-1:0]  w_alucode;

    logic [DATA_W-1:0] w_rf_rs1;
    logic [DATA_W-1:0] w_rf_rs2;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_imm_i;
    logic [DATA_W-1:0] w_imm_u;
    logic [DATA_W-1:0] w_shamt;
    alu_bundle_t       w_bundle;

    logic [REG_N-1:0]  w_wb_hot;
    logic [REG_N-1:0]  w_eff_busy;
    logic [REG_N-1:0]  w_busy_next;
    logic              w_hazard;
    logic              w_accept;
    logic              w_issue;

    alu_bundle_t       r_bundle;
    logic              r_out_valid;
    logic              r_illegal;
    logic [REG_N-1:0]  r_busy;

    // Instruction fields
    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_f3     = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_f7     = instr[31:25];

    // Legality and ALU code
    always_comb begin
        w_is_op    = (w_opcode == OPC_OP);
        w_is_opimm = (w_opcode == OPC_OPIMM);
        w_is_lui   = (w_opcode == OPC_LUI);
        w_is_shift = w_is_opimm && ((w_f3 == 3'b001) || (w_f3 == 3'b101));
        w_legal    = 1'b0;
        if (w_is_op) begin
            // Only SUB (000) and SRA (101) accept the alternate funct7
            w_legal = (w_f7 == F7_BASE) ||
                      ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        end else if (w_is_opimm) begin
            if (w_f3 == 3'b001) begin
                w_legal = (w_f7 == F7_BASE);
            end else if (w_f3 == 3'b101) begin
                w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            end else begin
                w_legal = 1'b1;
            end
        end else if (w_is_lui) begin
            w_legal = 1'b1;
        end

        // ADDI never becomes SUB: only R-type uses the alternate bit at funct3=000
        if (w_is_lui) begin
            w_alucode = CPY;
        end else if (w_f3 == 3'b000) begin
            w_alucode = alu_from_f3(w_f3, w_is_op && (w_f7 == F7_ALT));
        end else begin
            w_alucode = alu_from_f3(w_f3, w_f7 == F7_ALT);
        end
    end

    regfileR32I u_regfile (
        .clock      (clock),
        .reset      (reset),
        .i_we       (wb_en),
        .i_waddr    (wb_rd),
        .i_wdata    (wb_data),
        .i_raddr1   (w_rs1),
        .o_rdata1_c (w_rf_rs1),
        .i_raddr2   (w_rs2),
        .o_rdata2_c (w_rf_rs2)
    );

    // Writeback bypass: a value landing this cycle is forwarded to the operand
    assign w_rs1_val = (wb_en && (wb_rd == w_rs1) && (w_rs1 != '0)) ? wb_data : w_rf_rs1;
    assign w_rs2_val = (wb_en && (wb_rd == w_rs2) && (w_rs2 != '0)) ? wb_data : w_rf_rs2;

    assign w_imm_i = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_shamt = DATA_W'(instr[24:20]);

    // Operand selection
    always_comb begin
        w_bundle.a       = w_rs1_val;
        w_bundle.b       = w_rs2_val;
        w_bundle.alucode = w_alucode;
        w_bundle.rd      = w_rd;
        if (w_is_opimm) begin
            w_bundle.b = w_is_shift ? w_shamt : w_imm_i;
        end else if (w_is_lui) begin
            w_bundle.a = w_imm_u;
            w_bundle.b = w_imm_u;
        end
    end

    // Scoreboard: a register being written back this cycle no longer blocks
    always_comb begin
        w_wb_hot = '0;
        if (wb_en) begin
            w_wb_hot[wb_rd] = 1'b1;
        end
        w_eff_busy = r_busy & ~w_wb_hot;
    end

    // Illegal words bypass the hazard check since they never touch the scoreboard
    assign w_hazard = w_legal && (((w_is_op || w_is_opimm) && w_eff_busy[w_rs1]) ||
                                  (w_is_op && w_eff_busy[w_rs2]) ||
                                  w_eff_busy[w_rd]);

    assign instr_ready = !reset && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept    = instr_valid && instr_ready;
    assign w_issue     = w_accept && w_legal;

    // Next busy vector: writeback clears, issue sets, set wins on the same index
    always_comb begin
        w_busy_next = r_busy & ~w_wb_hot;
        if (w_issue) begin
            w_busy_next[w_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Output register (EMPTY/FULL tracked by r_out_valid) and scoreboard
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_illegal        <= 1'b0;
            r_bundle.a       <= '0;
            r_bundle.b       <= '0;
            r_bundle.alucode <= ADD;
            r_bundle.rd      <= '0;
            r_busy           <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_issue) begin
                r_bundle    <= w_bundle;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_busy <= w_busy_next;
        end
    end

    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;
    assign A         = r_bundle.a;
    assign B         = r_bundle.b;
    assign alucode   = r_bundle.alucode;
    assign rd        = r_bundle.rd;

endmodule

// File: tb/tb_decode_r32i.sv
// Directed self-checking bench for decode_r32i.
module tb_decode_r32i;
    import decode_r32i_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [ALU_W-1:0]  alucode;
    logic [IDX_W-1:0]  rd;
    logic              illegal;
    logic              wb_en;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    decode_r32i dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (A),
        .B           (B),
        .alucode     (alucode),
        .rd          (rd),
        .illegal     (illegal),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        out_ready   = 1'b1;
        wb_en       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        tick();
        tick();
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_alucode", 32'(alucode), 32'(ADD));
        chk("rst_rd", 32'(rd), 32'd0);
        reset       = 1'b0;
        instr_valid = 1'b0;

        // Seed x1=9, x2=4
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
        tick();
        wb_rd = 5'd2; wb_data = 32'd4;
        tick();
        wb_en = 1'b0;

        // ADD x3,x1,x2
        instr_valid = 1'b1; instr = 32'h002081B3;
        settle();
        chk("add_ready", 32'(instr_ready), 32'd1);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_A", A, 32'd9);
        chk("add_B", B, 32'd4);
        chk("add_code", 32'(alucode), 32'(ADD));
        chk("add_rd", 32'(rd), 32'd3);

        // ADDI x4,x0,-1 back-to-back
        instr = 32'hFFF00213;
        settle();
        chk("addi_ready", 32'(instr_ready), 32'd1);
        tick();
        chk("addi_A", A, 32'd0);
        chk("addi_B", B, 32'hFFFFFFFF);
        chk("addi_rd", 32'(rd), 32'd4);

        // SLTU x5,x4,x1 stalls on busy x4
        instr = 32'h001232B3;
        settle();
        chk("sltu_stall0", 32'(instr_ready), 32'd0);
        tick();
        chk("sltu_drain", 32'(out_valid), 32'd0);
        chk("sltu_stall1", 32'(instr_ready), 32'd0);
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hFFFFFFFF;
        settle();
        chk("sltu_wb_ready", 32'(instr_ready), 32'd1);
        tick();
        wb_en = 1'b0;
        chk("sltu_valid", 32'(out_valid), 32'd1);
        chk("sltu_A_bypass", A, 32'hFFFFFFFF);
        chk("sltu_B", B, 32'd9);
        chk("sltu_code", 32'(alucode), 32'(SLTU));
        chk("sltu_rd", 32'(rd), 32'd5);

        // SRAI x6,x1,3
        instr = 32'h4030D313;
        settle();
        chk("srai_ready", 32'(instr_ready), 32'd1);
        tick();
        chk("srai_A", A, 32'd9);
        chk("srai_B", B, 32'd3);
        chk("srai_code", 32'(alucode), 32'(SRA));
        chk("srai_rd", 32'(rd), 32'd6);

        // LUI x7,0xABCDE
        instr = 32'hABCDE3B7;
        tick();
        chk("lui_code", 32'(alucode), 32'(CPY));
        chk("lui_A", A, 32'hABCDE000);
        chk("lui_B", B, 32'hABCDE000);
        chk("lui_rd", 32'(rd), 32'd7);

        // Unsupported opcode 0x7F carrying rd=8
        instr = 32'h0000047F;
        settle();
        chk("ill_ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_novalid", 32'(out_valid), 32'd0);
        tick();
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_novalid2", 32'(out_valid), 32'd0);

        // R-type with funct7=0000001 is illegal and ignores the busy rd=x3
        instr_valid = 1'b1; instr = 32'h022081B3;
        settle();
        chk("ill7_ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("ill7_pulse", 32'(illegal), 32'd1);
        chk("ill7_novalid", 32'(out_valid), 32'd0);
        tick();
        chk("ill7_pulse_end", 32'(illegal), 32'd0);

        // Scoreboard untouched: x3 still busy, x8 still free
        instr_valid = 1'b1; instr = 32'h00018633;
        settle();
        chk("x3_busy", 32'(instr_ready), 32'd0);
        instr = 32'h000404B3;
        settle();
        chk("x8_free", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("x9_rd", 32'(rd), 32'd9);
        chk("x9_A", A, 32'd0);
        tick();

        // Backpressure: hold first bundle, then drain and reload in one edge
        out_ready = 1'b0;
        instr_valid = 1'b1; instr = 32'h00208533;
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_rd", 32'(rd), 32'd10);
        instr = 32'h402085B3;
        settle();
        chk("bp_blocked", 32'(instr_ready), 32'd0);
        tick();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_rd", 32'(rd), 32'd10);
        chk("bp_hold_code", 32'(alucode), 32'(ADD));
        out_ready = 1'b1;
        settle();
        chk("bp_release", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_rd", 32'(rd), 32'd11);
        chk("b2b_code", 32'(alucode), 32'(SUB));
        chk("b2b_A", A, 32'd9);
        chk("b2b_B", B, 32'd4);

        // Reset while FULL with x3 busy; writeback during reset is ignored
        out_ready = 1'b0;
        reset = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        tick();
        reset = 1'b0;
        wb_en = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        out_ready = 1'b1;
        instr_valid = 1'b1; instr = 32'h00118633;
        settle();
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_A", A, 32'd0);
        chk("post_rst_B", B, 32'd0);
        chk("post_rst_rd", 32'(rd), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
